id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-stage operand front end for the 5-stage RV32I core.
- Latches decoded fields from ID and resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and inserts a bubble on them.
- Drives the ALU's A, B and ALUControl inputs and the store-data path.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2, id_rd  in  REG_AW each  register indices.
- id_rd1, id_rd2  in  XLEN each  register-file read data.
- id_imm  in  XLEN  extended immediate.
- id_pc  in  XLEN  instruction PC.
- id_alu_control  in  3  ALU op.
- id_alu_src_b  in  1  1=immediate, 0=rs2.
- id_alu_src_a_pc  in  1  1=PC as A (AUIPC).
- id_reg_write  in  1  decoded control bit.
- id_mem_write  in  1  decoded control bit.
- id_branch  in  1  decoded control bit.
- id_jump  in  1  decoded control bit.
- id_result_src  in  2  00 ALU, 01 load, 10 PC+4.
- stall  in  1  downstream hold.
- flush  in  1  branch/jump redirect.
- mem_rd  in  REG_AW  MEM-stage destination.
- mem_reg_write  in  1  MEM-stage write enable.
- mem_alu_result  in  XLEN  MEM-stage result.
- wb_rd  in  REG_AW  WB-stage destination.
- wb_reg_write  in  1  WB-stage write enable.
- wb_result  in  XLEN  WB-stage result.
- load_use_hazard  out  1  combinational; front end must hold PC and IF/ID.
- ex_src_a, ex_src_b  out  XLEN each  ALU operands.
- ex_alu_control  out  3  ALU op.
- ex_write_data  out  XLEN  forwarded rs2, for stores.
- ex_rd  out  REG_AW  destination index.
- ex_pc  out  XLEN  instruction PC.
- ex_imm  out  XLEN  immediate.
- ex_valid  out  1  registered control.
- ex_reg_write  out  1  registered control.
- ex_mem_write  out  1  registered control.
- ex_branch  out  1  registered control.
- ex_jump  out  1  registered control.
- ex_result_src  out  2  registered control.

Behaviour:
- Reset (async, immediate): all registered fields are 0.
  - ex_valid, ex_reg_write, ex_mem_write, ex_branch and ex_jump are 0; ex_alu_control=000 (ADD); ex_result_src=00.
  - With registers at 0, ex_src_a/ex_src_b/ex_write_data read 0 unless a forward is active.
  - Deasserting reset mid-pipeline resumes in the bubble state.
- Latency: one cycle from ID inputs to registered EX fields. Forwarding and operand muxing are combinational after the register.
- Register update priority on each rising clk:
  1. flush=1 -> bubble: valid and all control bits 0, data fields don't-care but zeroed.
  2. else stall=1 -> hold all registered fields.
  3. else load_use_hazard=1 -> bubble.
  4. else -> load ID fields; valid=id_valid. If id_valid=0, control bits are also forced 0.
- Simultaneous flush and stall: flush wins.
- load_use_hazard is 1 iff all of:
  - ex_valid=1, ex_result_src=01 and ex_rd!=0;
  - ex_rd equals id_rs1 or id_rs2;
  - id_valid=1.
  It is independent of stall and flush.
- Forwarding, evaluated separately for rs1 and rs2 using the registered ex_rs1/ex_rs2:
  - MEM forward if mem_reg_write=1 and mem_rd!=0 and mem_rd==ex_rsN.
  - else WB forward if wb_reg_write=1 and wb_rd!=0 and wb_rd==ex_rsN.
  - else the registered rdN.
  - MEM has priority over WB. x0 is never forwarded.
- Operand selection:
  - ex_src_a = ex_pc if alu_src_a_pc, else fwd_rs1.
  - ex_src_b = ex_imm if alu_src_b, else fwd_rs2.
  - ex_write_data = fwd_rs2 always.
- Arithmetic: no arithmetic in this block; all paths are XLEN wide with no truncation.

Decomposition:
- Package core_pkg holds:
  - ALU op constants: ADD 000, SLL 001, SUB 010, XOR 100, SRL 101, OR 110, AND 111.
  - RESULT_SRC constants: ALU 00, LOAD 01, PC4 10.
  - A forwarding-select encoding: 00 reg, 01 WB, 10 MEM.
- One sub-module, forward_unit: purely combinational. Takes ex_rs1/ex_rs2 and the MEM/WB rd/write-enable signals; produces the two 2-bit select codes.

Test Plan:
- Reset mid-run with ex_reg_write=1 -> all control outputs 0 asynchronously, before the next clk edge.
- ADD x3,x1,x2 (rd1=5, rd2=7) then SUB x4,x3,x1 with mem_rd=3, mem_alu_result=12 -> ex_src_a=12, ex_src_b=5, ex_alu_control=010.
- mem_rd=wb_rd=6, mem_alu_result=0xAA, wb_result=0xBB, ex_rs2=6, alu_src_b=0 -> ex_src_b=0xAA. With mem_reg_write=0 -> 0xBB. With rd=0 on both -> the registered rd2.
- LW x5 in EX and id_rs1=5 -> load_use_hazard=1; next cycle ex_valid=0 and ex_reg_write=0. Repeat with ex_rd=0 -> no hazard.
- stall=1 for 3 cycles while ID changes -> EX fields unchanged. flush=1 with stall=1 -> bubble.
- SW with alu_src_b=1, imm=8, ex_rs2 matched by wb_rd, wb_result=0x1234 -> ex_src_b=8, ex_write_data=0x1234.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the RV32I execute-stage front end: ALU ops, result
// sources, forwarding selects and the registered EX control bundle.
package core_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // All-zero value of this bundle is the pipeline bubble.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic       alu_src_b;
    logic       alu_src_a_pc;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between ID, the MEM/WB forwarding sources and the ID/EX stage.
// The slave modport is the stage's view; master is the surrounding pipeline.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_rd1, id_rd2, id_imm, id_pc;
  logic [2:0]        id_alu_control;
  logic              id_alu_src_b, id_alu_src_a_pc;
  logic              id_reg_write, id_mem_write, id_branch, id_jump;
  logic [1:0]        id_result_src;
  logic              stall, flush;
  logic [REG_AW-1:0] mem_rd, wb_rd;
  logic              mem_reg_write, wb_reg_write;
  logic [XLEN-1:0]   mem_alu_result, wb_result;

  logic              load_use_hazard;
  logic [XLEN-1:0]   ex_src_a, ex_src_b, ex_write_data, ex_pc, ex_imm;
  logic [2:0]        ex_alu_control;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_valid, ex_reg_write, ex_mem_write, ex_branch, ex_jump;
  logic [1:0]        ex_result_src;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_pc,
           id_alu_control, id_alu_src_b, id_alu_src_a_pc, id_reg_write,
           id_mem_write, id_branch, id_jump, id_result_src, stall, flush,
           mem_rd, mem_reg_write, mem_alu_result, wb_rd, wb_reg_write, wb_result,
    output load_use_hazard, ex_src_a, ex_src_b, ex_alu_control, ex_write_data,
           ex_rd, ex_pc, ex_imm, ex_valid, ex_reg_write, ex_mem_write,
           ex_branch, ex_jump, ex_result_src
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_pc,
           id_alu_control, id_alu_src_b, id_alu_src_a_pc, id_reg_write,
           id_mem_write, id_branch, id_jump, id_result_src, stall, flush,
           mem_rd, mem_reg_write, mem_alu_result, wb_rd, wb_reg_write, wb_result,
    input  load_use_hazard, ex_src_a, ex_src_b, ex_alu_control, ex_write_data,
           ex_rd, ex_pc, ex_imm, ex_valid, ex_reg_write, ex_mem_write,
           ex_branch, ex_jump, ex_result_src
  );
endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// Combinational RAW forwarding select for the two EX source registers.
// MEM beats WB; x0 is never forwarded.
module forward_unit
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs1_i,
  input  logic [REG_AW-1:0] ex_rs2_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  output fwd_sel_e          fwd_a_o,
  output fwd_sel_e          fwd_b_o
);

  function automatic fwd_sel_e pick(input logic [REG_AW-1:0] rs);
    if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs)) return FWD_MEM;
    else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs)) return FWD_WB;
    else return FWD_REG;
  endfunction

  always_comb begin
    fwd_a_o = pick(ex_rs1_i);
    fwd_b_o = pick(ex_rs2_i);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and MEM/WB operand
// forwarding into the ALU A/B inputs and the store-data path.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  ex_ctrl_t          ctrl_q, ctrl_d, id_ctrl;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
  logic              load_use;
  fwd_sel_e          fwd_a, fwd_b;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

  assign load_use = ctrl_q.valid && (ctrl_q.result_src == RES_LOAD) && (rd_q != '0)
                    && ((rd_q == bus.id_rs1) || (rd_q == bus.id_rs2)) && bus.id_valid;

  always_comb begin
    id_ctrl = '{valid:        bus.id_valid,
                reg_write:    bus.id_reg_write,
                mem_write:    bus.id_mem_write,
                branch:       bus.id_branch,
                jump:         bus.id_jump,
                result_src:   bus.id_result_src,
                alu_control:  bus.id_alu_control,
                alu_src_b:    bus.id_alu_src_b,
                alu_src_a_pc: bus.id_alu_src_a_pc};
    if (!bus.id_valid) id_ctrl = '0;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    // Flush outranks stall; a load-use bubble only lands when not stalled.
    if (bus.flush || (!bus.stall && load_use)) begin
      ctrl_d = '0;
      rs1_d  = '0;
      rs2_d  = '0;
      rd_d   = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      pc_d   = '0;
    end else if (!bus.stall) begin
      ctrl_d = id_ctrl;
      rs1_d  = bus.id_rs1;
      rs2_d  = bus.id_rs2;
      rd_d   = bus.id_rd;
      rd1_d  = bus.id_rd1;
      rd2_d  = bus.id_rd2;
      imm_d  = bus.id_imm;
      pc_d   = bus.id_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
    end
  end

  forward_unit #(.REG_AW(REG_AW)) u_fwd (
    .ex_rs1_i        (rs1_q),
    .ex_rs2_i        (rs2_q),
    .mem_rd_i        (bus.mem_rd),
    .mem_reg_write_i (bus.mem_reg_write),
    .wb_rd_i         (bus.wb_rd),
    .wb_reg_write_i  (bus.wb_reg_write),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b)
  );

  always_comb begin
    case (fwd_a)
      FWD_MEM: fwd_rs1 = bus.mem_alu_result;
      FWD_WB:  fwd_rs1 = bus.wb_result;
      default: fwd_rs1 = rd1_q;
    endcase
    case (fwd_b)
      FWD_MEM: fwd_rs2 = bus.mem_alu_result;
      FWD_WB:  fwd_rs2 = bus.wb_result;
      default: fwd_rs2 = rd2_q;
    endcase
  end

  assign bus.load_use_hazard = load_use;
  assign bus.ex_src_a        = ctrl_q.alu_src_a_pc ? pc_q : fwd_rs1;
  assign bus.ex_src_b        = ctrl_q.alu_src_b ? imm_q : fwd_rs2;
  assign bus.ex_write_data   = fwd_rs2;
  assign bus.ex_alu_control  = ctrl_q.alu_control;
  assign bus.ex_rd           = rd_q;
  assign bus.ex_pc           = pc_q;
  assign bus.ex_imm          = imm_q;
  assign bus.ex_valid        = ctrl_q.valid;
  assign bus.ex_reg_write    = ctrl_q.reg_write;
  assign bus.ex_mem_write    = ctrl_q.mem_write;
  assign bus.ex_branch       = ctrl_q.branch;
  assign bus.ex_jump         = ctrl_q.jump;
  assign bus.ex_result_src   = ctrl_q.result_src;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes hand-computed expectations
// into a scoreboard queue; a negedge monitor drains and compares them.
module tb_id_ex_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int S_LUH = 0, S_SRCA = 1, S_SRCB = 2, S_ALUC = 3, S_WD = 4, S_RD = 5,
                 S_PC = 6, S_VALID = 7, S_RW = 8, S_MW = 9, S_BR = 10, S_JP = 11,
                 S_RES = 12;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int s);
    case (s)
      S_LUH:   return 32'(bus.load_use_hazard);
      S_SRCA:  return bus.ex_src_a;
      S_SRCB:  return bus.ex_src_b;
      S_ALUC:  return 32'(bus.ex_alu_control);
      S_WD:    return bus.ex_write_data;
      S_RD:    return 32'(bus.ex_rd);
      S_PC:    return bus.ex_pc;
      S_VALID: return 32'(bus.ex_valid);
      S_RW:    return 32'(bus.ex_reg_write);
      S_MW:    return 32'(bus.ex_mem_write);
      S_BR:    return 32'(bus.ex_branch);
      S_JP:    return 32'(bus.ex_jump);
      S_RES:   return 32'(bus.ex_result_src);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = actual(e.sig);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.val);
      end
    end
  end

  task automatic expect_v(input string name, input int sig, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic after_check();
    @(negedge clk);
    #1;
  endtask

  task automatic id_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [2:0] aluc,
                          input logic srcb, input logic srca_pc, input logic rw, input logic mw,
                          input logic [1:0] rsrc);
    bus.id_valid        = v;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    bus.id_rd           = rd;
    bus.id_rd1          = rd1;
    bus.id_rd2          = rd2;
    bus.id_imm          = imm;
    bus.id_pc           = pc;
    bus.id_alu_control  = aluc;
    bus.id_alu_src_b    = srcb;
    bus.id_alu_src_a_pc = srca_pc;
    bus.id_reg_write    = rw;
    bus.id_mem_write    = mw;
    bus.id_branch       = 1'b0;
    bus.id_jump         = 1'b0;
    bus.id_result_src   = rsrc;
  endtask

  initial begin
    reset              = 1'b1;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.mem_rd         = '0;
    bus.mem_reg_write  = 1'b0;
    bus.mem_alu_result = '0;
    bus.wb_rd          = '0;
    bus.wb_reg_write   = 1'b0;
    bus.wb_result      = '0;
    id_instr(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, RES_ALU);
    cyc();
    cyc();
    expect_v("rst_valid", S_VALID, 0);
    expect_v("rst_rw", S_RW, 0);
    expect_v("rst_aluc", S_ALUC, 0);
    expect_v("rst_res", S_RES, 0);
    expect_v("rst_srca", S_SRCA, 0);
    expect_v("rst_srcb", S_SRCB, 0);
    expect_v("rst_wd", S_WD, 0);
    expect_v("rst_luh", S_LUH, 0);
    after_check();
    reset = 1'b0;

    // ADD x3,x1,x2 then SUB x4,x3,x1 with x3 forwarded from MEM
    id_instr(1, 1, 2, 3, 5, 7, 0, 32'h10, ALU_ADD, 0, 0, 1, 0, RES_ALU);
    cyc();
    expect_v("add_srca", S_SRCA, 5);
    expect_v("add_srcb", S_SRCB, 7);
    expect_v("add_rd", S_RD, 3);
    expect_v("add_valid", S_VALID, 1);
    id_instr(1, 3, 1, 4, 32'h63, 5, 0, 32'h14, ALU_SUB, 0, 0, 1, 0, RES_ALU);
    cyc();
    bus.mem_rd = 3; bus.mem_reg_write = 1; bus.mem_alu_result = 12;
    expect_v("sub_srca", S_SRCA, 12);
    expect_v("sub_srcb", S_SRCB, 5);
    expect_v("sub_aluc", S_ALUC, 32'(ALU_SUB));

    // Forward priority on rs2, with EX held by stall
    id_instr(1, 0, 6, 7, 32'h11, 32'h22, 0, 32'h18, ALU_XOR, 0, 0, 1, 0, RES_ALU);
    cyc();
    bus.mem_rd = 6; bus.wb_rd = 6; bus.mem_reg_write = 1; bus.wb_reg_write = 1;
    bus.mem_alu_result = 32'hAA; bus.wb_result = 32'hBB; bus.stall = 1;
    expect_v("fwd_mem_b", S_SRCB, 32'hAA);
    expect_v("fwd_mem_wd", S_WD, 32'hAA);
    expect_v("fwd_a_reg", S_SRCA, 32'h11);
    cyc();
    bus.mem_reg_write = 0;
    expect_v("fwd_wb_b", S_SRCB, 32'hBB);
    cyc();
    bus.mem_reg_write = 1; bus.mem_rd = 0; bus.wb_rd = 0;
    expect_v("fwd_x0_b", S_SRCB, 32'h22);
    cyc();
    bus.mem_reg_write = 0; bus.wb_reg_write = 0; bus.stall = 0;

    // Load-use: LW x5 then ADD x6,x5,x2
    id_instr(1, 1, 0, 5, 0, 0, 4, 32'h20, ALU_ADD, 1, 0, 1, 0, RES_LOAD);
    cyc();
    id_instr(1, 5, 2, 6, 0, 0, 0, 32'h24, ALU_ADD, 0, 0, 1, 0, RES_ALU);
    expect_v("lu_hazard", S_LUH, 1);
    cyc();
    expect_v("lu_bubble_valid", S_VALID, 0);
    expect_v("lu_bubble_rw", S_RW, 0);
    expect_v("lu_after_bubble", S_LUH, 0);
    cyc();
    expect_v("lu_resume_valid", S_VALID, 1);
    expect_v("lu_resume_rd", S_RD, 6);
    id_instr(1, 0, 0, 5, 0, 0, 0, 32'h28, ALU_ADD, 1, 0, 1, 0, RES_LOAD);
    cyc();
    bus.stall = 1;
    id_instr(0, 0, 5, 9, 0, 0, 0, 32'h2C, ALU_ADD, 0, 0, 1, 0, RES_ALU);
    expect_v("lu_idvalid0", S_LUH, 0);
    cyc();
    id_instr(1, 0, 5, 9, 0, 0, 0, 32'h2C, ALU_ADD, 0, 0, 1, 0, RES_ALU);
    expect_v("lu_rs2_stalled", S_LUH, 1);
    after_check();
    bus.stall = 0;
    id_instr(1, 0, 0, 0, 0, 0, 0, 32'h30, ALU_ADD, 1, 0, 1, 0, RES_LOAD);
    cyc();
    id_instr(1, 0, 0, 8, 0, 0, 0, 32'h34, ALU_ADD, 0, 0, 1, 0, RES_ALU);
    expect_v("lu_x0", S_LUH, 0);
    expect_v("lu_x0_rd", S_RD, 0);

    // Stall hold for three cycles, then flush together with stall
    id_instr(1, 1, 2, 9, 0, 0, 32'h40, 32'h100, ALU_OR, 1, 1, 1, 0, RES_ALU);
    cyc();
    cyc();
    bus.stall = 1;
    id_instr(1, 3, 4, 10, 7, 7, 32'h80, 32'h200, ALU_AND, 0, 0, 0, 1, RES_ALU);
    expect_v("i1_srca_pc", S_SRCA, 32'h100);
    expect_v("i1_srcb_imm", S_SRCB, 32'h40);
    for (int k = 0; k < 3; k++) begin
      cyc();
      bus.id_pc = 32'h204 + 32'(4 * k);
      expect_v($sformatf("stall%0d_pc", k), S_PC, 32'h100);
      expect_v($sformatf("stall%0d_rd", k), S_RD, 9);
      expect_v($sformatf("stall%0d_aluc", k), S_ALUC, 32'(ALU_OR));
      expect_v($sformatf("stall%0d_valid", k), S_VALID, 1);
    end
    bus.flush = 1;
    cyc();
    bus.flush = 0; bus.stall = 0;
    expect_v("flush_valid", S_VALID, 0);
    expect_v("flush_rw", S_RW, 0);
    expect_v("flush_pc", S_PC, 0);
    expect_v("flush_rd", S_RD, 0);

    // SW: B from immediate, store data forwarded from WB
    id_instr(1, 2, 7, 0, 32'h50, 32'h999, 8, 32'h300, ALU_ADD, 1, 0, 0, 1, RES_ALU);
    cyc();
    bus.wb_rd = 7; bus.wb_reg_write = 1; bus.wb_result = 32'h1234;
    expect_v("sw_srcb", S_SRCB, 8);
    expect_v("sw_wd", S_WD, 32'h1234);
    expect_v("sw_srca", S_SRCA, 32'h50);
    expect_v("sw_mw", S_MW, 1);
    expect_v("sw_rw", S_RW, 0);

    // Jump/branch control pass-through, then id_valid=0 forcing controls low
    id_instr(1, 0, 0, 11, 0, 0, 0, 32'h400, ALU_ADD, 0, 0, 1, 0, RES_PC4);
    bus.id_branch = 1; bus.id_jump = 1;
    cyc();
    bus.wb_reg_write = 0;
    expect_v("jmp_br", S_BR, 1);
    expect_v("jmp_jp", S_JP, 1);
    expect_v("jmp_res", S_RES, 32'(RES_PC4));
    expect_v("jmp_rw", S_RW, 1);
    id_instr(0, 0, 0, 12, 0, 0, 0, 32'h404, ALU_ADD, 0, 0, 1, 1, RES_LOAD);
    bus.id_branch = 1; bus.id_jump = 1;
    cyc();
    expect_v("inv_valid", S_VALID, 0);
    expect_v("inv_rw", S_RW, 0);
    expect_v("inv_mw", S_MW, 0);
    expect_v("inv_br", S_BR, 0);
    expect_v("inv_res", S_RES, 0);
    expect_v("inv_rd", S_RD, 12);

    // Asynchronous reset while a writing instruction sits in EX
    id_instr(1, 0, 0, 13, 0, 0, 0, 32'h408, ALU_SUB, 0, 0, 1, 0, RES_ALU);
    bus.id_jump = 1;
    cyc();
    #1;
    reset = 1'b1;
    expect_v("ar_rw", S_RW, 0);
    expect_v("ar_valid", S_VALID, 0);
    expect_v("ar_jp", S_JP, 0);
    expect_v("ar_aluc", S_ALUC, 0);
    after_check();
    reset = 1'b0;

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
